note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//  Step sequencer that plays the synth voice: walks a small pattern RAM of oscillator
//  periods and drives the voice's osc_count and trig inputs at a programmable tempo.
//  Sits between the host config interface and the synth top, on the 20.48 MHz clock.
//  Gives each step a gated trig pulse for ADSR attack/release; note value 0 is a rest.
// PARAMETERS
//  STEPS    16  pattern depth (power of 2); AW = $clog2(STEPS)
//  TIME_W   24  width of step_len/gate_len, in clk cycles
//  NOTE_W   32  width of a note word (= oscillator count_max width)
// PORTS
//  clk        in   1       system clock, 20.48 MHz
//  rst        in   1       reset, asynchronous, active-high
//  start      in   1       1-cycle pulse: (re)start playback at step 0
//  stop       in   1       1-cycle pulse: stop playback
//  wr_en      in   1       pattern RAM write strobe
//  wr_addr    in   AW      pattern RAM write address
//  wr_note    in   NOTE_W  note word to write; 0 = rest
//  step_len   in   TIME_W  clk cycles per step
//  gate_len   in   TIME_W  clk cycles trig is high within a step
//  last_step  in   AW      index of final step in pattern
//  osc_count  out  NOTE_W  oscillator period to voice
//  trig       out  1       gate to ADSR (high = note held)
//  busy       out  1       high while playing
//  step       out  AW      index of step currently sounding
//  step_pulse out  1       high for first cycle of every step
// BEHAVIOUR
//  Reset: osc_count=0, trig=0, busy=0, step=0, step_pulse=0, FSM=IDLE. RAM not reset.
//  All outputs registered. FSM: IDLE -> PLAY -> (IDLE | PLAY).
//  IDLE: trig=0, busy=0, osc_count/step hold last value. start -> PLAY at step 0.
//  Latency: start sampled in cycle t; cycle t+1 is k=0 of step 0 (outputs valid, step_pulse=1).
//  Step load (k=0): latch step_len, gate_len, last_step; step_len<2 treated as 2;
//   gate_eff = min(gate_len, step_len_eff-1) (>=1 low cycle per step -> ADSR retrigger edge).
//   note = RAM[step]; if note!=0, osc_count<=note; if note==0, osc_count holds (release tail).
//  Within step, tick k = 0..step_len_eff-1: trig = (note!=0) && (k < gate_eff).
//  At k = step_len_eff-1: if step!=last_step, step<=step+1 and load next;
//   else end-of-pattern handling (see CONFIGURATION).
//  last_step >= STEPS impossible by width; last_step < current step at load -> end after current.
//  stop: next cycle IDLE, trig=0, busy=0, step_pulse=0; osc_count, step hold.
//  start while PLAY: restart at step 0 next cycle (k=0 rules apply).
//  start & stop same cycle: stop wins.
//  RAM write: one-cycle synchronous write, any time. Write to sounding step does not alter
//   osc_count until that step is next loaded; write to next step in the boundary cycle
//   (k=step_len_eff-1) is seen by that load (write-first).
//  Config inputs changed mid-step take effect at next step load only.
//  Reset asserted mid-playback: outputs go to reset values immediately (async).
// CONFIGURATION
//  SEQ_LOOP_EN defined: after last_step, wrap to step 0 with no gap (next cycle is k=0, step_pulse=1).
//  SEQ_LOOP_EN undefined: after last_step, one-shot: FSM -> IDLE, trig=0, busy=0, step holds.
// STRUCTURE
//  synth_pkg: seq_state_t enum {IDLE, PLAY}; localparam NOTE_REST = '0; SEQ_MIN_STEP = 2.
//  Sub-module seq_timer: tick counter with load/clear, outputs k==0, k<gate_eff, k==last.
//  Pattern RAM inline as reg array (no reset), FSM and output regs in note_sequencer.
// TESTING
//  1 Reset mid-play: rst during PLAY -> all outputs 0 same cycle; no activity until start.
//  2 RAM {1000,2000,0,4000}, last_step=3, step_len=10, gate_len=4, start ->
//    trig high 4 / low 6 per step, step 2 trig low with osc_count=2000, step_pulse every 10.
//  3 gate_len=20, step_len=10 -> trig high 9, low 1 per step; step_len=0 -> 2-cycle steps, trig 1/1.
//  4 End of pattern: with SEQ_LOOP_EN step 3 -> 0 without gap; without -> busy=0 after 40 cycles.
//  5 stop at k=5 of step 1 -> trig=0, busy=0 next cycle, osc_count=2000 held; start&stop same cycle -> IDLE.
//  6 Write RAM[1]=7777 during step 1 -> osc_count unchanged; next pass step 1 plays 7777;
//    write RAM[2] in boundary cycle of step 1 -> step 2 plays new value.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the note sequencer.
package synth_pkg;

  typedef enum logic {IDLE, PLAY} seq_state_t;

  localparam int unsigned NOTE_REST    = 0;
  localparam int unsigned SEQ_MIN_STEP = 2;

endpackage

// File: rtl/seq_timer.sv
// Per-step tick counter: loads step length and gate length at step start and
// flags the last gated tick and the last tick of the step.
module seq_timer #(
  parameter int unsigned TIME_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_run,
  input  logic [TIME_W-1:0] i_len,
  input  logic [TIME_W-1:0] i_gate,
  output logic              o_gate_end,
  output logic              o_last
);

  logic [TIME_W-1:0] r_k;
  logic [TIME_W-1:0] r_len;
  logic [TIME_W-1:0] r_gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_len  <= '0;
      r_gate <= '0;
    end else if (i_load) begin
      r_k    <= '0;
      r_len  <= i_len;
      r_gate <= i_gate;
    end else if (i_clear) begin
      r_k <= '0;
    end else if (i_run) begin
      r_k <= r_k + TIME_W'(1);
    end
  end

  // Gate end looks one tick ahead so the registered trig drops exactly at k == gate_eff.
  assign o_gate_end = (r_k + TIME_W'(1)) == r_gate;
  assign o_last     = r_k == (r_len - TIME_W'(1));

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer driving the synth voice from a small pattern RAM.
// Define SEQ_LOOP_EN to wrap the pattern endlessly; otherwise playback is one-shot.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned STEPS  = 16,
  parameter int unsigned TIME_W = 24,
  parameter int unsigned NOTE_W = 32,
  localparam int unsigned AW    = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [TIME_W-1:0] step_len,
  input  logic [TIME_W-1:0] gate_len,
  input  logic [AW-1:0]     last_step,
  output logic [NOTE_W-1:0] osc_count,
  output logic              trig,
  output logic              busy,
  output logic [AW-1:0]     step,
  output logic              step_pulse
);

  logic [NOTE_W-1:0] r_mem [STEPS];

  seq_state_t        r_state, w_state_d;
  logic [AW-1:0]     r_step, w_step_d;
  logic [AW-1:0]     r_last, w_last_d;
  logic [NOTE_W-1:0] r_osc, w_osc_d;
  logic              r_trig, w_trig_d;
  logic              r_busy, w_busy_d;
  logic              r_pulse, w_pulse_d;

  logic              w_load;
  logic              w_to_idle;
  logic [AW-1:0]     w_load_addr;
  logic [NOTE_W-1:0] w_load_note;
  logic              w_note_nz;
  logic [TIME_W-1:0] w_len_eff;
  logic [TIME_W-1:0] w_gate_eff;
  logic              w_gate_end;
  logic              w_step_last;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_note;
  end

  // Write-first so a write landing in the boundary cycle is seen by the load.
  always_comb begin
    w_len_eff   = (step_len < TIME_W'(SEQ_MIN_STEP)) ? TIME_W'(SEQ_MIN_STEP) : step_len;
    w_gate_eff  = (gate_len > (w_len_eff - TIME_W'(1))) ? (w_len_eff - TIME_W'(1)) : gate_len;
    w_load_note = (wr_en && (wr_addr == w_load_addr)) ? wr_note : r_mem[w_load_addr];
    w_note_nz   = w_load_note != NOTE_W'(NOTE_REST);
  end

  seq_timer #(
    .TIME_W (TIME_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_clear    (w_to_idle),
    .i_run      (r_state == PLAY),
    .i_len      (w_len_eff),
    .i_gate     (w_gate_eff),
    .o_gate_end (w_gate_end),
    .o_last     (w_step_last)
  );

  always_comb begin
    w_load      = 1'b0;
    w_to_idle   = 1'b0;
    w_load_addr = '0;
    if (stop) begin
      w_to_idle = 1'b1;
    end else if (start) begin
      w_load = 1'b1;
    end else if ((r_state == PLAY) && w_step_last) begin
      // A last_step below the current step also ends the pattern here.
      if (r_step < r_last) begin
        w_load      = 1'b1;
        w_load_addr = r_step + AW'(1);
      end else begin
`ifdef SEQ_LOOP_EN
        w_load = 1'b1;
`else
        w_to_idle = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_step_d  = r_step;
    w_last_d  = r_last;
    w_osc_d   = r_osc;
    w_trig_d  = r_trig;
    w_busy_d  = r_busy;
    w_pulse_d = 1'b0;
    if (w_to_idle) begin
      w_state_d = IDLE;
      w_trig_d  = 1'b0;
      w_busy_d  = 1'b0;
    end else if (w_load) begin
      w_state_d = PLAY;
      w_busy_d  = 1'b1;
      w_pulse_d = 1'b1;
      w_step_d  = w_load_addr;
      w_last_d  = last_step;
      if (w_note_nz) w_osc_d = w_load_note;
      w_trig_d  = w_note_nz && (w_gate_eff != '0);
    end else if ((r_state == PLAY) && w_gate_end) begin
      w_trig_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_last  <= '0;
      r_osc   <= '0;
      r_trig  <= 1'b0;
      r_busy  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_step  <= w_step_d;
      r_last  <= w_last_d;
      r_osc   <= w_osc_d;
      r_trig  <= w_trig_d;
      r_busy  <= w_busy_d;
      r_pulse <= w_pulse_d;
    end
  end

  assign osc_count  = r_osc;
  assign trig       = r_trig;
  assign busy       = r_busy;
  assign step       = r_step;
  assign step_pulse = r_pulse;

endmodule
